// File: rtl/skid_buffer_x65_pkg.sv
// Shared types and constants for the 2-entry skid buffer.
package skid_buffer_x65_pkg;

  localparam int LENGTH_DEF = 65;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Number of buffered beats held in a given state
  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_x65_if.sv
// Valid/ready stream in, valid/ready stream out, plus fill level.
interface skid_buffer_x65_if #(parameter int LENGTH = 65);
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [1:0]        occ;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  // Buffer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/skid_buffer_x65_en_dff_row.sv
// LENGTH-wide enabled register; both resets clear it to zero.
module en_dff_row #(
  parameter int LENGTH = 65
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              softReset,
  input  logic              i_en,
  input  logic [LENGTH-1:0] i_d,
  output logic [LENGTH-1:0] o_q
);
  logic [LENGTH-1:0] r_q;

  // Load on enable, clear on either reset; otherwise hold
  always_ff @(posedge clk) begin
    if (reset || softReset) r_q <= '0;
    else if (i_en)          r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/skid_buffer_x65.sv
// Two-entry skid buffer: main drives out_data, skid catches the beat
// accepted while downstream stalls. All handshake outputs are registered.
module skid_buffer_x65
  import skid_buffer_x65_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              softReset,
  skid_buffer_x65_if.slave  bus
);
  state_t            r_state, w_nxt;
  logic              r_in_ready, r_out_valid;
  logic [1:0]        r_occ;
  logic              w_in_fire, w_out_fire;
  logic              w_main_en, w_skid_en;
  logic [LENGTH-1:0] w_main_d, w_main_q, w_skid_q;

  // Next state and register write enables from the two fire conditions
  always_comb begin
    w_in_fire  = bus.in_valid & r_in_ready;
    w_out_fire = r_out_valid & bus.out_ready;
    w_nxt      = r_state;
    w_main_en  = 1'b0;
    w_skid_en  = 1'b0;
    w_main_d   = bus.in_data;
    case (r_state)
      ST_EMPTY: if (w_in_fire) begin
        w_main_en = 1'b1;
        w_nxt     = ST_ONE;
      end
      ST_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b11: w_main_en = 1'b1;
          2'b10: begin
            w_skid_en = 1'b1;
            w_nxt     = ST_FULL;
          end
          2'b01:   w_nxt = ST_EMPTY;
          default: w_nxt = ST_ONE;
        endcase
      end
      ST_FULL: if (w_out_fire) begin
        w_main_en = 1'b1;
        w_main_d  = w_skid_q;
        w_nxt     = ST_ONE;
      end
      default: w_nxt = ST_EMPTY;
    endcase
  end

  // FSM state with its handshake outputs registered alongside
  always_ff @(posedge clk) begin
    if (reset || softReset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_nxt;
      r_in_ready  <= (w_nxt != ST_FULL);
      r_out_valid <= (w_nxt != ST_EMPTY);
      r_occ       <= occ_of(w_nxt);
    end
  end

  en_dff_row #(.LENGTH(LENGTH)) u_main (
    .clk(clk), .reset(reset), .softReset(softReset),
    .i_en(w_main_en), .i_d(w_main_d), .o_q(w_main_q)
  );

  en_dff_row #(.LENGTH(LENGTH)) u_skid (
    .clk(clk), .reset(reset), .softReset(softReset),
    .i_en(w_skid_en), .i_d(bus.in_data), .o_q(w_skid_q)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_main_q;
  assign bus.occ       = r_occ;
endmodule

// File: tb/tb_skid_buffer_x65.sv
// Bench for skid_buffer_x65: directed vector table, then randomized
// traffic against a queue-based reference model.
module tb_skid_buffer_x65;
  localparam int L = 65;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic softReset = 1'b0;

  skid_buffer_x65_if #(.LENGTH(L)) bus ();

  skid_buffer_x65 #(.LENGTH(L)) dut (
    .clk(clk), .reset(reset), .softReset(softReset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         rst;
    logic         srst;
    logic         iv;
    logic [L-1:0] din;
    logic         ordy;
    logic         ev;
    logic         er;
    logic [1:0]   eocc;
    logic [L-1:0] edat;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic iv,
                       input logic [L-1:0] d, input logic ordy);
    reset         = r;
    softReset     = s;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  logic [L-1:0] q[$];
  logic [L-1:0] shown, prev_shown;
  logic         stall;

  initial begin
    drive(0, 0, 0, '0, 0);

    //           rst srst iv  din    ordy ev er occ  edat
    tv[0]  = '{1, 0, 0, 65'h0, 0, 0, 1, 2'd0, 65'h0}; // reset
    tv[1]  = '{0, 0, 1, 65'h1, 1, 1, 1, 2'd1, 65'h1}; // stream 1,2,3
    tv[2]  = '{0, 0, 1, 65'h2, 1, 1, 1, 2'd1, 65'h2};
    tv[3]  = '{0, 0, 1, 65'h3, 1, 1, 1, 2'd1, 65'h3};
    tv[4]  = '{0, 0, 0, 65'h0, 1, 0, 1, 2'd0, 65'h3}; // drain
    tv[5]  = '{0, 0, 1, 65'hA, 0, 1, 1, 2'd1, 65'hA}; // stall, push A
    tv[6]  = '{0, 0, 1, 65'hB, 0, 1, 0, 2'd2, 65'hA}; // push B -> full
    tv[7]  = '{0, 0, 1, 65'hC, 0, 1, 0, 2'd2, 65'hA}; // C refused
    tv[8]  = '{0, 0, 1, 65'hC, 0, 1, 0, 2'd2, 65'hA}; // C still refused
    tv[9]  = '{0, 0, 1, 65'hC, 1, 1, 1, 2'd1, 65'hB}; // pop A
    tv[10] = '{0, 0, 1, 65'hC, 1, 1, 1, 2'd1, 65'hC}; // pop B, take C
    tv[11] = '{0, 0, 0, 65'h0, 1, 0, 1, 2'd0, 65'hC}; // pop C
    tv[12] = '{0, 0, 1, 65'h5, 0, 1, 1, 2'd1, 65'h5};
    tv[13] = '{0, 0, 1, 65'h6, 0, 1, 0, 2'd2, 65'h5}; // full
    tv[14] = '{0, 1, 1, 65'hF, 0, 0, 1, 2'd0, 65'h0}; // softReset drops F
    tv[15] = '{0, 0, 0, 65'h0, 0, 0, 1, 2'd0, 65'h0};
    tv[16] = '{0, 0, 1, 65'h7, 1, 1, 1, 2'd1, 65'h7};
    tv[17] = '{0, 0, 1, 65'h8, 0, 1, 0, 2'd2, 65'h7};
    tv[18] = '{1, 1, 1, 65'h9, 1, 0, 1, 2'd0, 65'h0}; // both resets

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].rst, tv[i].srst, tv[i].iv, tv[i].din, tv[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("v%0d.out_valid", i), L'(bus.out_valid), L'(tv[i].ev));
      chk($sformatf("v%0d.in_ready",  i), L'(bus.in_ready),  L'(tv[i].er));
      chk($sformatf("v%0d.occ",       i), L'(bus.occ),       L'(tv[i].eocc));
      chk($sformatf("v%0d.out_data",  i), bus.out_data,      tv[i].edat);
    end

    // Randomized traffic: model is a FIFO of depth 2; out_data shows the
    // head, or the last head shown once the FIFO drains.
    drive(1, 0, 0, '0, 0);
    @(posedge clk); #1;
    q.delete();
    shown = '0;
    for (int c = 0; c < 10000; c++) begin
      logic [95:0]  rnd;
      logic         iv, ordy, sr, in_f, out_f;
      int           pr;
      rnd  = {$urandom(), $urandom(), $urandom()};
      pr   = (c / 500) % 3;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (pr == 0) ? ($urandom_range(0, 1) == 1) :
             (pr == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      sr   = ($urandom_range(0, 199) == 0);
      drive(0, sr, iv, rnd[L-1:0], ordy);

      prev_shown = shown;
      stall      = (q.size() > 0) && !ordy && !sr;
      if (sr) begin
        q.delete();
        shown = '0;
      end else begin
        in_f  = iv && (q.size() < 2);
        out_f = ordy && (q.size() > 0);
        if (out_f) void'(q.pop_front());
        if (in_f)  q.push_back(rnd[L-1:0]);
        if (q.size() > 0) shown = q[0];
      end

      @(posedge clk); #1;
      chk($sformatf("r%0d.out_valid", c), L'(bus.out_valid), L'(q.size() > 0));
      chk($sformatf("r%0d.in_ready",  c), L'(bus.in_ready),  L'(q.size() < 2));
      chk($sformatf("r%0d.occ",       c), L'(bus.occ),       L'(q.size()));
      chk($sformatf("r%0d.out_data",  c), bus.out_data,      shown);
      if (stall) chk($sformatf("r%0d.stall_hold", c), bus.out_data, prev_shown);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
